// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-requester arbiter in front of a single data memory
// Ports: clk, reset (async active-low); req_* from two requesters (valid/yumi),
// rsp_* back to them; mem_* request/response to the memory; protocol_err_o sticky
// flag for a memory response arriving when none is outstanding.
module dmem_arbiter #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   req_valid_i,
  input  logic [1:0]                   req_wen_i,
  input  logic [1:0]                   req_byte_i,
  input  logic [1:0][addr_width_p-1:0] req_addr_i,
  input  logic [1:0][data_width_p-1:0] req_wdata_i,
  output logic [1:0]                   req_yumi_o,
  output logic [1:0]                   rsp_valid_o,
  output logic [data_width_p-1:0]      rsp_data_o,
  input  logic [1:0]                   rsp_yumi_i,
  output logic                         mem_valid_o,
  output logic                         mem_wen_o,
  output logic                         mem_byte_o,
  output logic [addr_width_p-1:0]      mem_addr_o,
  output logic [data_width_p-1:0]      mem_wdata_o,
  input  logic                         mem_yumi_i,
  input  logic                         mem_rsp_valid_i,
  input  logic [data_width_p-1:0]      mem_rsp_data_i,
  output logic                         mem_rsp_yumi_o,
  output logic                         protocol_err_o
);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;
  state_e state_r, state_n;
  logic last_r, owner_r, g, grant, wen_r, byte_r;
  logic [addr_width_p-1:0] addr_r;
  logic [data_width_p-1:0] wdata_r;
  // grant is gated by reset so req_yumi_o is 0 while reset is held
  always_comb begin
    g = (&req_valid_i) ? ~last_r : req_valid_i[1];
    grant = reset && state_r == IDLE && |req_valid_i;
    req_yumi_o = grant ? {g, ~g} : 2'b00;
    mem_valid_o = state_r == REQ;
    rsp_valid_o = (state_r == RSP && mem_rsp_valid_i) ? {owner_r, ~owner_r} : 2'b00;
    mem_rsp_yumi_o = state_r == RSP && mem_rsp_valid_i && rsp_yumi_i[owner_r];
    state_n = grant ? REQ : (mem_valid_o && mem_yumi_i) ? RSP : mem_rsp_yumi_o ? IDLE : state_r;
  end
  assign mem_wen_o   = wen_r;
  assign mem_byte_o  = byte_r;
  assign mem_addr_o  = addr_r;
  assign mem_wdata_o = wdata_r;
  assign rsp_data_o  = mem_rsp_data_i;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_r <= IDLE;
    else state_r <= state_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      last_r <= 1'b1;
      owner_r <= 1'b0;
      wen_r <= 1'b0;
      byte_r <= 1'b0;
      addr_r <= '0;
      wdata_r <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      if (grant) begin
        last_r <= g;
        owner_r <= g;
        wen_r <= req_wen_i[g];
        byte_r <= req_byte_i[g];
        addr_r <= req_addr_i[g];
        wdata_r <= req_wdata_i[g];
      end
      if (mem_rsp_valid_i && state_r != RSP) protocol_err_o <= 1'b1;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  logic clk = 0, reset = 0;
  logic [1:0] req_valid_i, req_wen_i, req_byte_i, req_yumi_o, rsp_valid_o, rsp_yumi_i;
  logic [1:0][31:0] req_addr_i, req_wdata_i;
  logic [31:0] rsp_data_o, mem_addr_o, mem_wdata_o, mem_rsp_data_i;
  logic mem_valid_o, mem_wen_o, mem_byte_o, mem_yumi_i, mem_rsp_valid_i, mem_rsp_yumi_o, protocol_err_o;
  int errors = 0, checks = 0;
  typedef struct { int owner; logic [31:0] addr; logic [31:0] wdata; } txn_t;
  txn_t q[$];

  dmem_arbiter dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid_i), .req_wen_i(req_wen_i),
    .req_byte_i(req_byte_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_yumi_o(req_yumi_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .rsp_yumi_i(rsp_yumi_i), .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o),
    .mem_byte_o(mem_byte_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_yumi_i(mem_yumi_i), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_yumi_o(mem_rsp_yumi_o),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    req_valid_i = 0; req_wen_i = 0; req_byte_i = 0; req_addr_i = '0; req_wdata_i = '0;
    rsp_yumi_i = 0; mem_yumi_i = 0; mem_rsp_valid_i = 0; mem_rsp_data_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    reset = 0;
    req_valid_i = 2'b11;
    #1;
    checks++; if (req_yumi_o !== 2'b00) begin errors++; $display("FAIL reset_yumi got=%b exp=00", req_yumi_o); end
    checks++; if ({mem_valid_o, rsp_valid_o, mem_rsp_yumi_o, protocol_err_o} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=00000", {mem_valid_o, rsp_valid_o, mem_rsp_yumi_o, protocol_err_o}); end
    checks++; if ({mem_addr_o, mem_wdata_o} !== 64'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", {mem_addr_o, mem_wdata_o}); end
    clear_inputs();
    reset = 1;
  endtask

  task automatic test_single_load();
    do_reset();
    @(negedge clk);
    req_valid_i = 2'b01; req_addr_i[0] = 32'h10; req_wen_i = 2'b00;
    #1;
    checks++; if (req_yumi_o !== 2'b01) begin errors++; $display("FAIL load_grant got=%b exp=01", req_yumi_o); end
    @(negedge clk);
    req_valid_i = 0; mem_yumi_i = 1;
    #1;
    checks++; if ({mem_valid_o, mem_wen_o} !== 2'b10 || mem_addr_o !== 32'h10) begin errors++; $display("FAIL load_memreq got=%b/%h exp=10/00000010", {mem_valid_o, mem_wen_o}, mem_addr_o); end
    @(negedge clk);
    mem_yumi_i = 0; mem_rsp_valid_i = 1; mem_rsp_data_i = 32'hDEADBEEF; rsp_yumi_i = 2'b01;
    #1;
    checks++; if (rsp_valid_o !== 2'b01 || mem_rsp_yumi_o !== 1'b1) begin errors++; $display("FAIL load_rsp got=%b/%b exp=01/1", rsp_valid_o, mem_rsp_yumi_o); end
    checks++; if (rsp_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got=%h exp=deadbeef", rsp_data_o); end
    checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL load_memvalid_rsp got=%b exp=0", mem_valid_o); end
    @(negedge clk);
    clear_inputs();
    req_valid_i = 2'b10;
    #1;
    checks++; if (req_yumi_o !== 2'b10 || rsp_valid_o !== 2'b00) begin errors++; $display("FAIL load_idle got=%b/%b exp=10/00", req_yumi_o, rsp_valid_o); end
  endtask

  task automatic test_contention();
    int exp_order[4] = '{0, 1, 0, 1};
    int k = 0, done = 0;
    logic pend = 0;
    logic [1:0] bump = 0;
    logic [31:0] wd0 = 32'hA000_0000, wd1 = 32'hB000_0000;
    txn_t t;
    do_reset();
    q.delete();
    for (int c = 0; c < 60 && done < 4; c++) begin
      @(negedge clk);
      if (bump[0]) wd0++;
      if (bump[1]) wd1++;
      req_valid_i = 2'b11; req_wen_i = 2'b11;
      req_addr_i[0] = 32'h100; req_addr_i[1] = 32'h200;
      req_wdata_i[0] = wd0; req_wdata_i[1] = wd1;
      mem_yumi_i = 1; mem_rsp_valid_i = pend; mem_rsp_data_i = 32'h5000 + c; rsp_yumi_i = 2'b11;
      #1;
      bump = req_yumi_o;
      if (req_yumi_o !== 2'b00) begin
        checks++;
        if (k >= 4 || req_yumi_o !== 2'(1 << exp_order[k])) begin errors++; $display("FAIL cont_grant idx=%0d got=%b", k, req_yumi_o); end
        else begin
          t.owner = exp_order[k]; t.addr = req_addr_i[t.owner]; t.wdata = req_wdata_i[t.owner];
          q.push_back(t);
        end
        k++;
      end
      if (mem_valid_o) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL cont_memreq got=unexpected exp=none"); end
        else if (mem_wdata_o !== q[0].wdata || mem_addr_o !== q[0].addr || mem_wen_o !== 1'b1) begin
          errors++; $display("FAIL cont_memreq got=%h/%h exp=%h/%h", mem_addr_o, mem_wdata_o, q[0].addr, q[0].wdata);
        end
        pend = 1;
      end
      if (mem_rsp_yumi_o) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL cont_rsp got=unexpected exp=none"); end
        else begin
          t = q.pop_front();
          if (rsp_valid_o !== 2'(1 << t.owner) || rsp_data_o !== mem_rsp_data_i) begin errors++; $display("FAIL cont_rsp got=%b exp=%b", rsp_valid_o, 2'(1 << t.owner)); end
        end
        pend = 0;
        done++;
      end
    end
    checks++; if (done !== 4) begin errors++; $display("FAIL cont_timeout got=%0d exp=4", done); end
    checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL cont_err got=%b exp=0", protocol_err_o); end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    req_valid_i = 2'b10; req_addr_i[1] = 32'h30;
    #1;
    checks++; if (req_yumi_o !== 2'b10) begin errors++; $display("FAIL bp_grant got=%b exp=10", req_yumi_o); end
    @(negedge clk);
    req_valid_i = 0; mem_yumi_i = 1;
    @(negedge clk);
    mem_yumi_i = 0; mem_rsp_valid_i = 1; mem_rsp_data_i = 32'h1234; rsp_yumi_i = 2'b01; req_valid_i = 2'b01;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (rsp_valid_o !== 2'b10 || mem_rsp_yumi_o !== 1'b0 || req_yumi_o !== 2'b00) begin
        errors++; $display("FAIL bp_hold cyc=%0d got=%b/%b/%b exp=10/0/00", i, rsp_valid_o, mem_rsp_yumi_o, req_yumi_o);
      end
    end
    @(negedge clk);
    rsp_yumi_i = 2'b10;
    #1;
    checks++; if (mem_rsp_yumi_o !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", mem_rsp_yumi_o); end
    @(negedge clk);
    mem_rsp_valid_i = 0; rsp_yumi_i = 0;
    #1;
    checks++; if (req_yumi_o !== 2'b01) begin errors++; $display("FAIL bp_next_grant got=%b exp=01", req_yumi_o); end
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    req_valid_i = 2'b01; req_wen_i = 2'b01; req_byte_i = 2'b01; req_addr_i[0] = 32'h44; req_wdata_i[0] = 32'hCAFE0001;
    #1;
    checks++; if (req_yumi_o !== 2'b01) begin errors++; $display("FAIL stall_grant got=%b exp=01", req_yumi_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid_i = 0; req_addr_i[0] = 32'h99 + i; req_wdata_i[0] = 32'h0BAD0000 + i; mem_yumi_i = 0;
      #1;
      checks++;
      if ({mem_valid_o, mem_wen_o, mem_byte_o} !== 3'b111 || mem_addr_o !== 32'h44 || mem_wdata_o !== 32'hCAFE0001) begin
        errors++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%h exp=111/00000044/cafe0001", i, {mem_valid_o, mem_wen_o, mem_byte_o}, mem_addr_o, mem_wdata_o);
      end
    end
    @(negedge clk);
    mem_yumi_i = 1;
    #1;
    checks++; if (mem_valid_o !== 1'b1) begin errors++; $display("FAIL stall_accept got=%b exp=1", mem_valid_o); end
    @(negedge clk);
    mem_yumi_i = 0; mem_rsp_valid_i = 1; rsp_yumi_i = 2'b01;
    #1;
    checks++; if (rsp_valid_o !== 2'b01 || mem_valid_o !== 1'b0) begin errors++; $display("FAIL stall_rsp got=%b/%b exp=01/0", rsp_valid_o, mem_valid_o); end
  endtask

  task automatic test_spurious();
    do_reset();
    @(negedge clk);
    mem_rsp_valid_i = 1; rsp_yumi_i = 2'b11;
    #1;
    checks++; if (rsp_valid_o !== 2'b00 || mem_rsp_yumi_o !== 1'b0) begin errors++; $display("FAIL spur_rsp got=%b/%b exp=00/0", rsp_valid_o, mem_rsp_yumi_o); end
    checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL spur_pre got=%b exp=0", protocol_err_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_rsp_valid_i = 0; rsp_yumi_i = 0;
      #1;
      checks++; if (protocol_err_o !== 1'b1) begin errors++; $display("FAIL spur_sticky cyc=%0d got=%b exp=1", i, protocol_err_o); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    req_valid_i = 2'b01; req_addr_i[0] = 32'h80; req_wdata_i[0] = 32'h77;
    @(negedge clk);
    req_valid_i = 0; mem_yumi_i = 1;
    @(negedge clk);
    mem_yumi_i = 0; mem_rsp_valid_i = 1; rsp_yumi_i = 0; req_valid_i = 2'b11;
    #1;
    checks++; if (rsp_valid_o !== 2'b01) begin errors++; $display("FAIL mid_rsp got=%b exp=01", rsp_valid_o); end
    #2;
    reset = 0;
    #1;
    checks++;
    if ({req_yumi_o, mem_valid_o, rsp_valid_o, mem_rsp_yumi_o, protocol_err_o} !== 7'b0 || {mem_addr_o, mem_wdata_o} !== 64'h0) begin
      errors++; $display("FAIL mid_reset got=%b/%h exp=0/0", {req_yumi_o, mem_valid_o, rsp_valid_o, mem_rsp_yumi_o, protocol_err_o}, {mem_addr_o, mem_wdata_o});
    end
    @(negedge clk);
    mem_rsp_valid_i = 0;
    reset = 1;
    #1;
    checks++; if (req_yumi_o !== 2'b01) begin errors++; $display("FAIL mid_tie got=%b exp=01", req_yumi_o); end
    checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL mid_err got=%b exp=0", protocol_err_o); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_load();
    test_contention();
    test_backpressure();
    test_stall();
    test_spurious();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
